// File: rtl/adder_sched_pkg.sv
// Shared constants, state encoding and helpers for the round-robin adder scheduler.
package adder_sched_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_t;

  function automatic int words(input int width);
    return width / WORD_W;
  endfunction

endpackage

// File: rtl/adder_share_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  logic found;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (en && !found && req[(int'(ptr) + off) % N]) begin
        gnt[(int'(ptr) + off) % N] = 1'b1;
        found                      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/brentkung_32bit.sv
// 32-bit Brent-Kung parallel-prefix adder with carry-in and carry-out.
module brentkung_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] half;
  logic [31:0] grp_g;

  // Up-sweep builds prefixes at positions 2^k-1; down-sweep fills the rest.
  always_comb begin : prefix_tree
    logic [31:0] g;
    logic [31:0] p;
    half = a ^ b;
    g    = a & b;
    p    = half;
    g[0] = g[0] | (p[0] & cin);
    for (int l = 0; l < 5; l++) begin
      for (int i = (2 << l) - 1; i < 32; i += (2 << l)) begin
        g[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p[i] = p[i] & p[i - (1 << l)];
      end
    end
    for (int l = 3; l >= 0; l--) begin
      for (int i = (3 << l) - 1; i < 32; i += (2 << l)) begin
        g[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p[i] = p[i] & p[i - (1 << l)];
      end
    end
    grp_g = g;
  end

  assign sum  = half ^ {grp_g[30:0], cin};
  assign cout = grp_g[31];

endmodule

// File: rtl/adder_share_sched.sv
// Shares one 32-bit adder among NUM_REQ clients; each WIDTH-bit add runs LS word first
// with the inter-word carry held in a register.
module adder_share_sched
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]         req_cin,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout,
  output logic                       busy
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int WORDS  = words(WIDTH);
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  if ((WIDTH % WORD_W) != 0 || NUM_REQ < 2) begin : g_bad_params
    $error("adder_share_sched: WIDTH must be a multiple of 32 and NUM_REQ >= 2");
  end

  sched_state_t state, state_nxt;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    ptr;
  logic [WIDX_W-1:0]  word_idx;
  logic               carry;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WORD_W-1:0]  add_sum;
  logic               add_cout;
  logic               accept;
  logic               last_word;

  rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  (state == IDLE),
    .gnt (gnt)
  );

  brentkung_32bit u_add (
    .a    (a_q[word_idx*WORD_W +: WORD_W]),
    .b    (b_q[word_idx*WORD_W +: WORD_W]),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_id = ID_W'(i);
    end
  end

  assign accept    = (state == IDLE) && (|req_valid);
  assign last_word = (word_idx == WIDX_W'(WORDS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = RUN;
      RUN:     if (last_word)  state_nxt = DONE;
      DONE:    if (rsp_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = gnt;
    rsp_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry    <= 1'b0;
      ptr      <= '0;
      word_idx <= '0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id   <= gnt_id;
            carry    <= req_cin[gnt_id];
            word_idx <= '0;
            ptr      <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          end
        end
        RUN: begin
          rsp_sum[word_idx*WORD_W +: WORD_W] <= add_sum;
          carry    <= add_cout;
          word_idx <= word_idx + 1'b1;
          if (last_word) rsp_cout <= add_cout;
        end
        default: ;
      endcase
    end
  end

  // NOTE: operand latches carry no reset; they are always loaded at accept before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= req_a[gnt_id*WIDTH +: WIDTH];
      b_q <= req_b[gnt_id*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_adder_share_sched.sv
// Directed self-checking bench for adder_share_sched (128-bit and 32-bit instances).
module tb_adder_share_sched;

  localparam int NR = 4;
  localparam int W  = 128;
  localparam int W2 = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic [NR-1:0]   req_cin;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_sum;
  logic            rsp_cout;
  logic            busy;

  logic [NR-1:0]    s_valid;
  logic [NR-1:0]    s_ready;
  logic [NR*W2-1:0] s_a;
  logic [NR*W2-1:0] s_b;
  logic [NR-1:0]    s_cin;
  logic             s_rsp_valid;
  logic             s_rsp_ready;
  logic [1:0]       s_rsp_id;
  logic [W2-1:0]    s_rsp_sum;
  logic             s_rsp_cout;
  logic             s_busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always #5 clk = ~clk;

  adder_share_sched #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  adder_share_sched #(.NUM_REQ(NR), .WIDTH(W2)) dut32 (
    .clk(clk), .rst_n(rst_n), .req_valid(s_valid), .req_ready(s_ready),
    .req_a(s_a), .req_b(s_b), .req_cin(s_cin), .rsp_valid(s_rsp_valid),
    .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id), .rsp_sum(s_rsp_sum), .rsp_cout(s_rsp_cout),
    .busy(s_busy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = cin;
    req_valid[i]    = 1'b1;
  endtask

  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  // Single isolated request: grant strobe, latency, result, then return to IDLE.
  task automatic run_one(input string tag, input int idx, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] exp_sum, input logic exp_cout);
    int n;
    set_req(idx, a, b, cin);
    #1;
    check({tag, "_grant"}, W'(req_ready), W'(1 << idx));
    step();
    req_valid[idx] = 1'b0;
    #1;
    check({tag, "_ready_drop"}, W'(req_ready), '0);
    check({tag, "_busy"}, W'(busy), W'(1));
    wait_rsp(n);
    check({tag, "_latency"}, W'(n), W'(5));
    check({tag, "_id"}, W'(rsp_id), W'(idx));
    check({tag, "_sum"}, rsp_sum, exp_sum);
    check({tag, "_cout"}, W'(rsp_cout), W'(exp_cout));
    step();
    check({tag, "_idle"}, W'({busy, rsp_valid}), '0);
  endtask

  initial begin
    int n;
    int last;
    int e;
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b1;
    s_valid = '0; s_a = '0; s_b = '0; s_cin = '0; s_rsp_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_ready", W'(req_ready), '0);
    check("rst_valid", W'(rsp_valid), '0);
    check("rst_id", W'(rsp_id), '0);
    check("rst_sum", rsp_sum, '0);
    check("rst_cout", W'(rsp_cout), '0);
    check("rst_busy", W'(busy), '0);

    // Carry across the 64-bit word boundary.
    run_one("t1", 2, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0,
            128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0);
    // Carry-in ripples through all four words and out.
    run_one("t2", 0, {128{1'b1}}, 128'h0, 1'b1, 128'h0, 1'b1);
    run_one("t2b", 1, 128'h0123456789ABCDEF_FEDCBA9876543210,
            128'h1111111111111111_1111111111111111, 1'b1,
            128'h123456789ABCDF01_0FEDCBA987654322, 1'b0);
    run_one("t2c", 3, 128'h8000_0000_0000_0000_0000_0000_0000_0000,
            128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b0, 128'h1, 1'b1);

    // All four requesters valid after reset: order 0,1,2,3,0 with 6-cycle spacing.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, W'(i + 1), W'(10), 1'b0);
    #1;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      e = g % NR;
      n = 0;
      while (req_ready == '0 && n < 20) begin
        step();
        n++;
      end
      check("t3_grant", W'(req_ready), W'(1 << e));
      if (g > 0) check("t3_spacing", W'(cyc - last), W'(6));
      last = cyc;
      step();
      wait_rsp(n);
      check("t3_valid", W'(rsp_valid), W'(1));
      check("t3_id", W'(rsp_id), W'(e));
      check("t3_sum", rsp_sum, W'(e + 11));
    end
    req_valid = '0;
    step();

    // Stall in DONE holds the result and blocks new grants (pointer now at 1).
    rsp_ready = 1'b0;
    set_req(2, W'(5), W'(7), 1'b1);
    #1;
    check("t4_grant2", W'(req_ready), W'(4'b0100));
    step();
    req_valid[2] = 1'b0;
    wait_rsp(n);
    check("t4_latency", W'(n), W'(5));
    set_req(1, W'(100), W'(200), 1'b0);
    #1;
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", W'(rsp_valid), W'(1));
      check("t4_hold_sum", rsp_sum, W'(13));
      check("t4_hold_ready", W'(req_ready), '0);
      step();
    end
    check("t4_hold_id", W'(rsp_id), W'(2));
    rsp_ready = 1'b1;
    step();
    check("t4_grant1", W'(req_ready), W'(4'b0010));
    step();
    req_valid[1] = 1'b0;
    wait_rsp(n);
    check("t4_id1", W'(rsp_id), W'(1));
    check("t4_sum1", rsp_sum, W'(300));
    step();

    // Reset in RUN at word 2; afterwards the pointer is back at 0 so req 1 wins over req 3.
    set_req(3, W'(32'hFFFF_FFFF), W'(1), 1'b0);
    #1;
    check("t5_grant3", W'(req_ready), W'(4'b1000));
    step();
    step();
    step();
    set_req(1, W'(3), W'(4), 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_run_ready", W'(req_ready), '0);
    check("t5_run_busy", W'(busy), W'(1));
    step();
    rst_n = 1'b1;
    #1;
    check("t5_busy", W'(busy), '0);
    check("t5_valid", W'(rsp_valid), '0);
    check("t5_sum", rsp_sum, '0);
    check("t5_id", W'(rsp_id), '0);
    check("t5_grant1", W'(req_ready), W'(4'b0010));
    step();
    req_valid[1] = 1'b0;
    wait_rsp(n);
    check("t5_id1", W'(rsp_id), W'(1));
    check("t5_sum1", rsp_sum, W'(7));
    step();
    #1;
    check("t5_regrant3", W'(req_ready), W'(4'b1000));
    step();
    req_valid[3] = 1'b0;
    wait_rsp(n);
    check("t5_id3", W'(rsp_id), W'(3));
    check("t5_sum3", rsp_sum, 128'h1_0000_0000);
    step();

    // Single-word configuration: two-cycle latency, carry out of bit 31.
    s_a[1*W2 +: W2] = 32'hFFFF_FFFF;
    s_b[1*W2 +: W2] = 32'h1;
    s_cin[1]        = 1'b0;
    s_valid[1]      = 1'b1;
    #1;
    check("t6_grant", W'(s_ready), W'(4'b0010));
    step();
    s_valid[1] = 1'b0;
    n = 1;
    while (!s_rsp_valid && n < 20) begin
      step();
      n++;
    end
    check("t6_latency", W'(n), W'(2));
    check("t6_id", W'(s_rsp_id), W'(1));
    check("t6_sum", W'(s_rsp_sum), '0);
    check("t6_cout", W'(s_rsp_cout), W'(1));
    step();
    check("t6_idle", W'(s_busy), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
